// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and types for the RV32I memory stage.
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RDATA} mem_state_t;
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic        misalign;
  } wb_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane/byte-enable generation, load extraction/extension, misalign detection.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  always_comb begin
    byte_sel   = rdata_i[{off_i, 3'b000} +: 8];
    half_sel   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o       = funct3_i[1:0] == F3_SB[1:0] ? 4'b0001 << off_i :
                 funct3_i[1:0] == F3_SH[1:0] ? 4'b0011 << off_i : 4'b1111;
    wdata_o    = funct3_i[1:0] == F3_SB[1:0] ? {4{wdata_i[7:0]}} :
                 funct3_i[1:0] == F3_SH[1:0] ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o    = funct3_i == F3_LB  ? {{24{byte_sel[7]}}, byte_sel} :
                 funct3_i == F3_LH  ? {{16{half_sel[15]}}, half_sel} :
                 funct3_i == F3_LBU ? {24'b0, byte_sel} :
                 funct3_i == F3_LHU ? {16'b0, half_sel} : rdata_i;
    misalign_o = funct3_i[1:0] == F3_LH[1:0] ? off_i[0] :
                 funct3_i[1:0] == F3_LW[1:0] ? |off_i : 1'b0;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with req/gnt/rvalid bus FSM and MEM/WB register.
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] AluResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW
);
  mem_state_t  state_q, state_d;
  wb_t         wb_q, wb_d;
  logic [3:0]  be;
  logic [31:0] load_data;
  logic        misalign, mem_op, access, complete;
  lsu_align u_align (
    .funct3_i  (Funct3M),
    .off_i     (AluResultM[1:0]),
    .wdata_i   (WriteDataM),
    .rdata_i   (dmem_rdata),
    .be_o      (be),
    .wdata_o   (dmem_wdata),
    .rdata_o   (load_data),
    .misalign_o(misalign)
  );
  assign mem_op    = ValidM & (MemReadM | MemWriteM);
  assign access    = mem_op & ~misalign;
  assign complete  = ValidM & ~StallM;
  assign dmem_we   = dmem_req & MemWriteM;
  assign dmem_addr = {AluResultM[31:2], 2'b00};
  assign dmem_be   = dmem_req ? be : 4'b0000;
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    StallM   = 1'b0;
    case (state_q)
      IDLE, WAIT_GNT: begin
        dmem_req = access;
        StallM   = access & (~dmem_gnt | MemReadM);
        state_d  = ~access ? IDLE : ~dmem_gnt ? WAIT_GNT : MemReadM ? WAIT_RDATA : IDLE;
      end
      WAIT_RDATA: begin
        StallM  = ~dmem_rvalid;
        state_d = dmem_rvalid ? IDLE : WAIT_RDATA;
      end
      default: state_d = IDLE;
    endcase
  end
  // Bubbles only clear the valid-like fields; the data fields keep their last value.
  always_comb begin
    wb_d           = wb_q;
    wb_d.reg_write = 1'b0;
    wb_d.misalign  = 1'b0;
    if (complete) begin
      wb_d.reg_write  = RegWriteM & ~(mem_op & misalign);
      wb_d.result_src = ResultSrcM;
      wb_d.alu_result = AluResultM;
      wb_d.read_data  = load_data;
      wb_d.rd         = RdM;
      wb_d.pc_plus4   = PCPlus4M;
      wb_d.misalign   = mem_op & misalign;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end
  assign RegWriteW  = wb_q.reg_write;
  assign ResultSrcW = wb_q.result_src;
  assign AluResultW = wb_q.alu_result;
  assign ReadDataW  = wb_q.read_data;
  assign RdW        = wb_q.rd;
  assign PCPlus4W   = wb_q.pc_plus4;
  assign MisalignW  = wb_q.misalign;
endmodule
